// File: rtl/dpram_be_fwd.sv
// dpram_be_fwd: parametrised true dual-port RAM with per-lane write enables,
// explicit read enables with a valid flag, 0..2 extra output pipeline stages
// and deterministic cross-port same-address collision handling:
//   - write/write: lanes enabled on A take A's data, lanes only on B take B's
//   - read/write : a read sees the other port's same-cycle write (write-first)
// The array itself is never reset; only the read pipeline is.
// Legal parameter space: NUM_WORDS <= 2**AWIDTH, DWIDTH % LANE_W == 0,
// OUT_REGS in {0, 1, 2}.
module dpram_be_fwd #(
    parameter int AWIDTH    = 12,
    parameter int NUM_WORDS = 4096,
    parameter int DWIDTH    = 64,
    parameter int LANE_W    = 8,
    parameter int OUT_REGS  = 0
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [AWIDTH-1:0]          address_a,
    input  logic [AWIDTH-1:0]          address_b,
    input  logic                       wren_a,
    input  logic                       wren_b,
    input  logic [DWIDTH/LANE_W-1:0]   ben_a,
    input  logic [DWIDTH/LANE_W-1:0]   ben_b,
    input  logic                       rden_a,
    input  logic                       rden_b,
    input  logic [DWIDTH-1:0]          data_a,
    input  logic [DWIDTH-1:0]          data_b,
    output logic [DWIDTH-1:0]          out_a,
    output logic [DWIDTH-1:0]          out_b,
    output logic                       valid_a,
    output logic                       valid_b
);

    localparam int NUM_LANES = DWIDTH / LANE_W;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int NSTAGE    = OUT_REGS + 1;
    // One extra bit so NUM_WORDS == 2**AWIDTH does not wrap to zero.
    localparam logic [AWIDTH:0] ADDR_LIM = (AWIDTH+1)'(NUM_WORDS);

    // Overlay the enabled lanes of wdata onto base.
    function automatic logic [DWIDTH-1:0] merge_lanes(
        input logic [DWIDTH-1:0]    base,
        input logic [DWIDTH-1:0]    wdata,
        input logic [NUM_LANES-1:0] ben
    );
        logic [DWIDTH-1:0] res;
        res = base;
        for (int l = 0; l < NUM_LANES; l++) begin
            res[l*LANE_W +: LANE_W] = ben[l] ? wdata[l*LANE_W +: LANE_W]
                                             : base[l*LANE_W +: LANE_W];
        end
        return res;
    endfunction

    logic [DWIDTH-1:0] mem_r [NUM_WORDS];

    logic              in_rng_a_s, in_rng_b_s;
    logic              wr_a_s, wr_b_s;
    logic              rd_a_s, rd_b_s;
    logic              same_addr_s;
    logic [IDX_W-1:0]  idx_a_s, idx_b_s;
    logic [DWIDTH-1:0] raw_a_s, raw_b_s;
    logic [DWIDTH-1:0] fwd_a_s, fwd_b_s;

    logic [DWIDTH-1:0] pipe_a_r [NSTAGE];
    logic [DWIDTH-1:0] pipe_b_r [NSTAGE];
    logic              vld_a_r  [NSTAGE];
    logic              vld_b_r  [NSTAGE];

    assign in_rng_a_s  = ({1'b0, address_a} < ADDR_LIM);
    assign in_rng_b_s  = ({1'b0, address_b} < ADDR_LIM);
    assign idx_a_s     = address_a[IDX_W-1:0];
    assign idx_b_s     = address_b[IDX_W-1:0];
    assign same_addr_s = (address_a == address_b);

    // A write with no enabled lane or an out-of-range address touches nothing.
    assign wr_a_s = wren_a & in_rng_a_s & (|ben_a);
    assign wr_b_s = wren_b & in_rng_b_s & (|ben_b);

    // A write request on a port always suppresses that port's read.
    assign rd_a_s = rden_a & ~wren_a;
    assign rd_b_s = rden_b & ~wren_b;

    // Out-of-range reads return zero; in-range reads forward the other
    // port's same-cycle lanes (wr_x_s already implies the shared address
    // is in range).
    assign raw_a_s = in_rng_a_s ? mem_r[idx_a_s] : {DWIDTH{1'b0}};
    assign raw_b_s = in_rng_b_s ? mem_r[idx_b_s] : {DWIDTH{1'b0}};
    assign fwd_a_s = (wr_b_s && same_addr_s) ? merge_lanes(raw_a_s, data_b, ben_b) : raw_a_s;
    assign fwd_b_s = (wr_a_s && same_addr_s) ? merge_lanes(raw_b_s, data_a, ben_a) : raw_b_s;

    // Lane-wise array update; A's lanes are applied last so A wins a collision.
    always_ff @(posedge clk) begin
        for (int l = 0; l < NUM_LANES; l++) begin
            if (wr_b_s && ben_b[l]) begin
                mem_r[idx_b_s][l*LANE_W +: LANE_W] <= data_b[l*LANE_W +: LANE_W];
            end
        end
        for (int l = 0; l < NUM_LANES; l++) begin
            if (wr_a_s && ben_a[l]) begin
                mem_r[idx_a_s][l*LANE_W +: LANE_W] <= data_a[l*LANE_W +: LANE_W];
            end
        end
    end

    // Read pipeline: valid advances every cycle, data only moves with valid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < NSTAGE; k++) begin
                pipe_a_r[k] <= {DWIDTH{1'b0}};
                pipe_b_r[k] <= {DWIDTH{1'b0}};
                vld_a_r[k]  <= 1'b0;
                vld_b_r[k]  <= 1'b0;
            end
        end else begin
            vld_a_r[0] <= rd_a_s;
            vld_b_r[0] <= rd_b_s;
            if (rd_a_s) begin
                pipe_a_r[0] <= fwd_a_s;
            end
            if (rd_b_s) begin
                pipe_b_r[0] <= fwd_b_s;
            end
            for (int k = 1; k < NSTAGE; k++) begin
                vld_a_r[k] <= vld_a_r[k-1];
                vld_b_r[k] <= vld_b_r[k-1];
                if (vld_a_r[k-1]) begin
                    pipe_a_r[k] <= pipe_a_r[k-1];
                end
                if (vld_b_r[k-1]) begin
                    pipe_b_r[k] <= pipe_b_r[k-1];
                end
            end
        end
    end

    assign out_a   = pipe_a_r[NSTAGE-1];
    assign out_b   = pipe_b_r[NSTAGE-1];
    assign valid_a = vld_a_r[NSTAGE-1];
    assign valid_b = vld_b_r[NSTAGE-1];

endmodule

// File: tb/tb_dpram_be_fwd.sv
// Bench for dpram_be_fwd: three instances (OUT_REGS = 0, 1, 2) share one set
// of inputs, so each vector is checked at each instance's own latency.
module tb_dpram_be_fwd;

    localparam int AW = 12;
    localparam int DW = 64;
    localparam int NL = 8;
    localparam int ND = 3000;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [AW-1:0] address_a, address_b;
    logic          wren_a, wren_b, rden_a, rden_b;
    logic [NL-1:0] ben_a, ben_b;
    logic [DW-1:0] data_a, data_b;

    logic [DW-1:0] oa_w [3];
    logic [DW-1:0] ob_w [3];
    logic          va_w [3];
    logic          vb_w [3];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dpram_be_fwd #(
            .AWIDTH(AW), .NUM_WORDS(ND), .DWIDTH(DW), .LANE_W(8), .OUT_REGS(g)
        ) u_dut (
            .clk(clk), .resetn(resetn),
            .address_a(address_a), .address_b(address_b),
            .wren_a(wren_a), .wren_b(wren_b),
            .ben_a(ben_a), .ben_b(ben_b),
            .rden_a(rden_a), .rden_b(rden_b),
            .data_a(data_a), .data_b(data_b),
            .out_a(oa_w[g]), .out_b(ob_w[g]),
            .valid_a(va_w[g]), .valid_b(vb_w[g])
        );
    end

    typedef struct {
        logic          wa; logic ra; logic [NL-1:0] ba; logic [AW-1:0] aa; logic [DW-1:0] da;
        logic          wb; logic rb; logic [NL-1:0] bb; logic [AW-1:0] ab; logic [DW-1:0] db;
        logic          va; logic [DW-1:0] oa;
        logic          vb; logic [DW-1:0] ob;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic idle();
        wren_a = 1'b0; wren_b = 1'b0; rden_a = 1'b0; rden_b = 1'b0;
        ben_a = 8'h00; ben_b = 8'h00;
        address_a = 12'd0; address_b = 12'd0;
        data_a = 64'h0; data_b = 64'h0;
    endtask

    // Drive one vector for one cycle, then check instance k after k+1 edges.
    task automatic apply_vec(input vec_t v, input int id);
        @(negedge clk);
        wren_a = v.wa; rden_a = v.ra; ben_a = v.ba; address_a = v.aa; data_a = v.da;
        wren_b = v.wb; rden_b = v.rb; ben_b = v.bb; address_b = v.ab; data_b = v.db;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (k == 0) idle();
            chk($sformatf("v%0d u%0d valid_a", id, k), 64'(va_w[k]), 64'(v.va));
            chk($sformatf("v%0d u%0d valid_b", id, k), 64'(vb_w[k]), 64'(v.vb));
            if (v.va) chk($sformatf("v%0d u%0d out_a", id, k), oa_w[k], v.oa);
            if (v.vb) chk($sformatf("v%0d u%0d out_b", id, k), ob_w[k], v.ob);
        end
    endtask

    function automatic logic [DW-1:0] sw_d(input int i);
        logic [7:0] b;
        b = 8'h10 + 8'(i);
        return {8{b}};
    endfunction

    initial begin
        // wa ra ba aa da | wb rb bb ab db | va oa | vb ob
        vecs[0]  = '{1'b1,1'b0,8'hFF,12'd5,64'h1122334455667788, 1'b0,1'b0,8'h00,12'd0,64'h0, 1'b0,64'h0, 1'b0,64'h0};
        vecs[1]  = '{1'b0,1'b0,8'h00,12'd0,64'h0, 1'b1,1'b0,8'h0F,12'd5,64'hAAAAAAAAAAAAAAAA, 1'b0,64'h0, 1'b0,64'h0};
        vecs[2]  = '{1'b0,1'b1,8'h00,12'd5,64'h0, 1'b0,1'b1,8'h00,12'd5,64'h0, 1'b1,64'h11223344AAAAAAAA, 1'b1,64'h11223344AAAAAAAA};
        vecs[3]  = '{1'b1,1'b0,8'hF0,12'd9,64'h0101010101010101, 1'b1,1'b0,8'hFF,12'd9,64'h0202020202020202, 1'b0,64'h0, 1'b0,64'h0};
        vecs[4]  = '{1'b0,1'b1,8'h00,12'd9,64'h0, 1'b0,1'b0,8'h00,12'd0,64'h0, 1'b1,64'h0101010102020202, 1'b0,64'h0};
        vecs[5]  = '{1'b1,1'b0,8'hFF,12'd3,64'h0, 1'b0,1'b0,8'h00,12'd0,64'h0, 1'b0,64'h0, 1'b0,64'h0};
        vecs[6]  = '{1'b1,1'b0,8'h03,12'd3,64'hFFFFFFFFFFFFFFFF, 1'b0,1'b1,8'h00,12'd3,64'h0, 1'b0,64'h0, 1'b1,64'h000000000000FFFF};
        vecs[7]  = '{1'b0,1'b0,8'h00,12'd0,64'h0, 1'b0,1'b1,8'h00,12'd3,64'h0, 1'b0,64'h0, 1'b1,64'h000000000000FFFF};
        vecs[8]  = '{1'b1,1'b1,8'h00,12'd3,64'h1234123412341234, 1'b0,1'b0,8'h00,12'd0,64'h0, 1'b0,64'h0, 1'b0,64'h0};
        vecs[9]  = '{1'b0,1'b1,8'h00,12'd3,64'h0, 1'b0,1'b0,8'h00,12'd0,64'h0, 1'b1,64'h000000000000FFFF, 1'b0,64'h0};
        vecs[10] = '{1'b1,1'b1,8'hFF,12'd0,64'h5555555555555555, 1'b0,1'b0,8'h00,12'd0,64'h0, 1'b0,64'h0, 1'b0,64'h0};
        vecs[11] = '{1'b0,1'b1,8'h00,12'd0,64'h0, 1'b0,1'b0,8'h00,12'd0,64'h0, 1'b1,64'h5555555555555555, 1'b0,64'h0};
        vecs[12] = '{1'b1,1'b0,8'hFF,12'd3000,64'hDEADBEEFDEADBEEF, 1'b0,1'b1,8'h00,12'd3000,64'h0, 1'b0,64'h0, 1'b1,64'h0};
        vecs[13] = '{1'b0,1'b1,8'h00,12'd0,64'h0, 1'b0,1'b0,8'h00,12'd0,64'h0, 1'b1,64'h5555555555555555, 1'b0,64'h0};
        vecs[14] = '{1'b0,1'b1,8'h00,12'd9,64'h0, 1'b1,1'b0,8'h01,12'd9,64'hFFFFFFFFFFFFFFFF, 1'b1,64'h01010101020202FF, 1'b0,64'h0};
        vecs[15] = '{1'b0,1'b1,8'h00,12'd9,64'h0, 1'b0,1'b0,8'h00,12'd0,64'h0, 1'b1,64'h01010101020202FF, 1'b0,64'h0};

        idle();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset u%0d out_a", k), oa_w[k], 64'h0);
            chk($sformatf("reset u%0d out_b", k), ob_w[k], 64'h0);
            chk($sformatf("reset u%0d valid_a", k), 64'(va_w[k]), 64'h0);
            chk($sformatf("reset u%0d valid_b", k), 64'(vb_w[k]), 64'h0);
        end
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 16; i++) apply_vec(vecs[i], i);

        // Fill addr 0..7, then read them back-to-back and go idle.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            wren_a = 1'b1; ben_a = 8'hFF; address_a = AW'(i); data_a = sw_d(i);
        end
        @(negedge clk);
        idle();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            idle();
            if (c < 8) begin
                rden_a = 1'b1; address_a = AW'(c);
            end
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
                int t;
                int lat;
                t   = c + 1;
                lat = k + 1;
                chk($sformatf("sweep c%0d u%0d valid_a", c, k), 64'(va_w[k]),
                    ((t >= lat) && (t < lat + 8)) ? 64'h1 : 64'h0);
                if (t >= lat)
                    chk($sformatf("sweep c%0d u%0d out_a", c, k), oa_w[k],
                        sw_d((t - lat < 8) ? (t - lat) : 7));
            end
        end

        // Reset asserted with reads in flight on both ports.
        @(negedge clk);
        idle();
        rden_a = 1'b1; address_a = 12'd5;
        rden_b = 1'b1; address_b = 12'd9;
        @(posedge clk); #1;
        idle();
        #2 resetn = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("midrst u%0d out_a", k), oa_w[k], 64'h0);
            chk($sformatf("midrst u%0d out_b", k), ob_w[k], 64'h0);
            chk($sformatf("midrst u%0d valid_a", k), 64'(va_w[k]), 64'h0);
            chk($sformatf("midrst u%0d valid_b", k), 64'(vb_w[k]), 64'h0);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("postrst c%0d u%0d valid_a", c, k), 64'(va_w[k]), 64'h0);
                chk($sformatf("postrst c%0d u%0d valid_b", c, k), 64'(vb_w[k]), 64'h0);
            end
        end

        // Array contents survive reset.
        begin
            vec_t v;
            v = '{1'b0,1'b1,8'h00,12'd5,64'h0, 1'b0,1'b1,8'h00,12'd7,64'h0, 1'b1,sw_d(5), 1'b1,sw_d(7)};
            apply_vec(v, 16);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
